// File: rtl/byte_lane_lsu_pkg.sv
// -----------------------------------------------------------------------------
// byte_lane_lsu_pkg
//   Shared types and helpers for the byte-lane load/store sequencer.
//   - size_e     : request size encodings (byte / half / word / reserved)
//   - state_e    : sequencer states
//   - bytes_for_size() : number of RAM byte accesses a request size needs
// -----------------------------------------------------------------------------
package byte_lane_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // The reserved size never reaches the RAM, so it reports zero bytes.
  function automatic logic [2:0] bytes_for_size(input size_e size);
    case (size)
      SZ_BYTE: bytes_for_size = 3'd1;
      SZ_HALF: bytes_for_size = 3'd2;
      SZ_WORD: bytes_for_size = 3'd4;
      default: bytes_for_size = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_lsu_load_extend.sv
// -----------------------------------------------------------------------------
// lsu_load_extend
//   Combinational zero/sign extension of the little-endian assembly register
//   into the 32-bit load result.
//   Ports:
//     asm_data  in  32  assembled load bytes (byte k in bits [8k+7:8k])
//     size      in  2   request size (size_e)
//     is_signed in  1   sign-extend from the top captured bit
//     rdata     out 32  extended result (0 for the reserved size)
// -----------------------------------------------------------------------------
module lsu_load_extend
  import byte_lane_lsu_pkg::*;
(
  input  logic [31:0] asm_data,
  input  size_e       size,
  input  logic        is_signed,
  output logic [31:0] rdata
);

  logic fill;

  always_comb begin
    // NOTE: outputs get a value before the case so no branch leaves them
    // unassigned; an unassigned path in always_comb would infer a latch.
    rdata = '0;
    fill  = 1'b0;
    case (size)
      SZ_BYTE: begin
        fill  = is_signed & asm_data[7];
        rdata = {{24{fill}}, asm_data[7:0]};
      end
      SZ_HALF: begin
        fill  = is_signed & asm_data[15];
        rdata = {{16{fill}}, asm_data[15:0]};
      end
      SZ_WORD: rdata = asm_data;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/byte_lane_lsu.sv
// -----------------------------------------------------------------------------
// byte_lane_lsu
//   Load/store sequencer in front of the 8-bit RAM port A. One byte/half/word
//   request is split into little-endian byte accesses (ADDR then WAIT per
//   byte, WAIT stretched by ram_busy). Loads are assembled and extended; every
//   request ends with a one-cycle resp_valid pulse.
//
//   Build option: define BYTE_LANE_LSU_ALIGN_CHECK_EN to reject odd-address
//   halves and non-word-aligned words with resp_err and no RAM access.
//   Without it, misaligned requests run bytewise; only size 11 errors.
//
//   Ports:
//     clk, reset      clock; synchronous active-high reset
//     req_*           request handshake (valid/ready), write, size, signed,
//                     byte address, store data
//     resp_valid      one-cycle completion pulse
//     resp_rdata      load result, held until the next response (0 for stores)
//     resp_err        qualifies resp_valid: request rejected
//     ram_addr/wdata/we  RAM byte port drive (registered)
//     ram_rdata/busy  RAM read byte and not-ready indication
// -----------------------------------------------------------------------------
module byte_lane_lsu
  import byte_lane_lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [1:0]               req_size,
  input  logic                     req_signed,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [31:0]              req_wdata,

  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     resp_err,

  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [7:0]               ram_wdata,
  output logic                     ram_we,
  input  logic [7:0]               ram_rdata,
  input  logic                     ram_busy
);

  state_e                   state_q,     state_d;
  logic                     write_q,     write_d;
  size_e                    size_q,      size_d;
  logic                     signed_q,    signed_d;
  logic [ADDRESS_WIDTH-1:0] addr_q,      addr_d;
  logic [31:0]              wdata_q,     wdata_d;
  logic [1:0]               k_q,         k_d;
  logic [31:0]              asm_q,       asm_d;
  logic [ADDRESS_WIDTH-1:0] ram_addr_q,  ram_addr_d;
  logic [7:0]               ram_wdata_q, ram_wdata_d;
  logic                     ram_we_q,    ram_we_d;
  logic [31:0]              rdata_q,     rdata_d;
  logic                     err_q,       err_d;

  size_e       req_size_e;
  logic        misaligned;
  logic [1:0]  k_next;
  logic        last_byte;
  logic [31:0] ext_rdata;

  assign req_size_e = size_e'(req_size);
  assign k_next     = k_q + 2'd1;
  assign last_byte  = ({1'b0, k_q} + 3'd1) == bytes_for_size(size_q);

`ifdef BYTE_LANE_LSU_ALIGN_CHECK_EN
  assign misaligned = ((req_size_e == SZ_HALF) && req_addr[0]) ||
                      ((req_size_e == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Byte assembly lives in its own process so the extender can look at the
  // value that includes the final byte being captured this cycle.
  always_comb begin
    asm_d = asm_q;
    if ((state_q == ST_IDLE) && req_valid) begin
      asm_d = '0;
    end else if ((state_q == ST_WAIT) && !ram_busy && !write_q) begin
      asm_d[{k_q, 3'b000} +: 8] = ram_rdata;
    end
  end

  lsu_load_extend u_load_extend (
    .asm_data  (asm_d),
    .size      (size_q),
    .is_signed (signed_q),
    .rdata     (ext_rdata)
  );

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    signed_d    = signed_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    k_d         = k_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;      // write strobe only ever lasts the ADDR cycle
    rdata_d     = rdata_q;   // result is held between responses
    err_d       = 1'b0;      // error flag only lives in the DONE cycle

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size_e;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          k_d      = '0;
          if ((req_size_e == SZ_RSVD) || misaligned) begin
            // Rejected: RAM port registers are left untouched.
            state_d = ST_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d     = ST_ADDR;
            ram_addr_d  = req_addr;
            ram_wdata_d = req_wdata[7:0];
            ram_we_d    = req_write;
          end
        end
      end

      ST_ADDR: state_d = ST_WAIT;

      ST_WAIT: begin
        if (!ram_busy) begin
          if (last_byte) begin
            state_d = ST_DONE;
            rdata_d = write_q ? 32'h0 : ext_rdata;
          end else begin
            state_d     = ST_ADDR;
            k_d         = k_next;
            // Address wraps modulo 2^ADDRESS_WIDTH by plain truncation.
            ram_addr_d  = addr_q + ADDRESS_WIDTH'(k_next);
            ram_wdata_d = wdata_q[{k_next, 3'b000} +: 8];
            ram_we_d    = write_q;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      size_q      <= SZ_BYTE;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      k_q         <= '0;
      asm_q       <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      k_q         <= k_d;
      asm_q       <= asm_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE) & ~reset;
  assign resp_valid = (state_q == ST_DONE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_we     = ram_we_q;

endmodule

// File: tb/tb_byte_lane_lsu.sv
// -----------------------------------------------------------------------------
// tb_byte_lane_lsu
//   Directed bench for byte_lane_lsu. A small address-keyed RAM model supplies
//   read bytes; each request is logged cycle by cycle (cycle 1 = first cycle
//   after the accept edge) and compared with hand-computed values.
// -----------------------------------------------------------------------------
module tb_byte_lane_lsu;

  localparam int AW   = 32;
  localparam int MAXC = 40;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic [7:0]    ram_rdata;
  logic          ram_busy;

  int n_tests = 0;
  int n_fail  = 0;

  int            resp_cycle;
  logic [31:0]   got_rdata;
  logic          got_err;
  int            we_count;
  logic          log_we    [0:MAXC];
  logic [AW-1:0] log_addr  [0:MAXC];
  logic [7:0]    log_wdata [0:MAXC];

  byte_lane_lsu #(.ADDRESS_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata),
    .ram_busy   (ram_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ram_model(input logic [AW-1:0] a);
    case (a)
      32'h0000_0020: return 8'h80;
      32'h0000_0030: return 8'h34;
      32'h0000_0031: return 8'h12;
      32'h0000_0041: return 8'h56;
      32'h0000_0042: return 8'h78;
      32'h0000_0050: return 8'h7F;
      32'hFFFF_FFFE: return 8'hA1;
      32'hFFFF_FFFF: return 8'hB2;
      32'h0000_0000: return 8'hC3;
      32'h0000_0001: return 8'hD4;
      default:       return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always_comb ram_rdata = ram_model(ram_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; returns at a negedge with the DUT
  // idle again. ram_busy is high during cycles [busy_from, busy_from+busy_len).
  task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [AW-1:0] addr, input logic [31:0] wd,
                         input int busy_from, input int busy_len);
    for (int c = 0; c <= MAXC; c++) begin
      log_we[c]    = 1'b0;
      log_addr[c]  = '0;
      log_wdata[c] = '0;
    end
    resp_cycle = -1;
    we_count   = 0;
    got_rdata  = '0;
    got_err    = 1'b0;
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= MAXC && resp_cycle < 0; c++) begin
      @(negedge clk);
      log_we[c]    = ram_we;
      log_addr[c]  = ram_addr;
      log_wdata[c] = ram_wdata;
      if (ram_we) we_count++;
      ram_busy = (c >= busy_from) && (c < busy_from + busy_len);
      if (resp_valid) begin
        resp_cycle = c;
        got_rdata  = resp_rdata;
        got_err    = resp_err;
        ram_busy   = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic saw_resp;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    ram_busy   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready",  32'(req_ready),  32'd0);
    check("rst_rvalid", 32'(resp_valid), 32'd0);
    check("rst_rdata",  resp_rdata,      32'h0);
    check("rst_err",    32'(resp_err),   32'd0);
    check("rst_addr",   ram_addr,        32'h0);
    check("rst_wdata",  32'(ram_wdata),  32'h0);
    check("rst_we",     32'(ram_we),     32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // Word store 0x11223344 at 0x10
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 0, 0);
    check("st_w_cycle", 32'(resp_cycle), 32'd9);
    check("st_w_err",   32'(got_err),    32'd0);
    check("st_w_rdata", got_rdata,       32'h0);
    check("st_w_wecnt", 32'(we_count),   32'd4);
    check("st_w_we0",   32'(log_we[1]),  32'd1);
    check("st_w_we3",   32'(log_we[7]),  32'd1);
    check("st_w_a0",    log_addr[1],     32'h10);
    check("st_w_a1",    log_addr[3],     32'h11);
    check("st_w_a2",    log_addr[5],     32'h12);
    check("st_w_a3",    log_addr[7],     32'h13);
    check("st_w_d0",    32'(log_wdata[1]), 32'h44);
    check("st_w_d1",    32'(log_wdata[3]), 32'h33);
    check("st_w_d2",    32'(log_wdata[5]), 32'h22);
    check("st_w_d3",    32'(log_wdata[7]), 32'h11);

    // Byte loads at 0x20 (RAM 0x80), signed and unsigned
    run_req(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 0, 0);
    check("ld_bs_cycle", 32'(resp_cycle), 32'd3);
    check("ld_bs_rdata", got_rdata,       32'hFFFF_FF80);
    check("ld_bs_wecnt", 32'(we_count),   32'd0);
    run_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 0, 0);
    check("ld_bu_cycle", 32'(resp_cycle), 32'd3);
    check("ld_bu_rdata", got_rdata,       32'h0000_0080);

    // Signed byte with clear top bit stays positive
    run_req(1'b0, 2'b00, 1'b1, 32'h50, 32'h0, 0, 0);
    check("ld_b7f_rdata", got_rdata, 32'h0000_007F);

    // Half load at 0x30 with busy for 3 cycles in the first WAIT
    run_req(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 2, 3);
    check("ld_h_cycle", 32'(resp_cycle), 32'd8);
    check("ld_h_rdata", got_rdata,       32'h0000_1234);
    check("ld_h_a1",    log_addr[6],     32'h31);

    // Word load wrapping the address space
    run_req(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0, 0, 0);
    check("ld_wrap_cycle", 32'(resp_cycle), 32'd9);
    check("ld_wrap_a0",    log_addr[1],     32'hFFFF_FFFE);
    check("ld_wrap_a1",    log_addr[3],     32'hFFFF_FFFF);
    check("ld_wrap_a2",    log_addr[5],     32'h0000_0000);
    check("ld_wrap_a3",    log_addr[7],     32'h0000_0001);
    check("ld_wrap_rdata", got_rdata,       32'hD4C3_B2A1);
    check("ld_wrap_hold",  resp_rdata,      32'hD4C3_B2A1);

    // Half at odd address 0x41
    run_req(1'b0, 2'b01, 1'b0, 32'h41, 32'h0, 0, 0);
`ifdef BYTE_LANE_LSU_ALIGN_CHECK_EN
    check("mis_h_cycle", 32'(resp_cycle), 32'd1);
    check("mis_h_err",   32'(got_err),    32'd1);
    check("mis_h_rdata", got_rdata,       32'h0);
    check("mis_h_wecnt", 32'(we_count),   32'd0);
    check("mis_h_addr",  log_addr[1],     32'h1);
`else
    check("mis_h_cycle", 32'(resp_cycle), 32'd5);
    check("mis_h_err",   32'(got_err),    32'd0);
    check("mis_h_a0",    log_addr[1],     32'h41);
    check("mis_h_a1",    log_addr[3],     32'h42);
    check("mis_h_rdata", got_rdata,       32'h0000_7856);
`endif

    // Reserved size: error in every build, no RAM write
    run_req(1'b1, 2'b11, 1'b0, 32'h70, 32'hDEAD_BEEF, 0, 0);
    check("rsvd_cycle", 32'(resp_cycle), 32'd1);
    check("rsvd_err",   32'(got_err),    32'd1);
    check("rsvd_rdata", got_rdata,       32'h0);
    check("rsvd_wecnt", 32'(we_count),   32'd0);

    // Reset during the third byte of a word store
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_addr   = 32'h60;
    req_wdata  = 32'hAABB_CCDD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("rstmid_we_b2",   32'(ram_we),    32'd1);
    check("rstmid_addr_b2", ram_addr,       32'h62);
    check("rstmid_data_b2", 32'(ram_wdata), 32'hBB);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_we",     32'(ram_we),     32'd0);
    check("rstmid_rvalid", 32'(resp_valid), 32'd0);
    check("rstmid_ready",  32'(req_ready),  32'd0);
    reset = 1'b0;
    saw_resp = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
    end
    check("rstmid_no_resp",   32'(saw_resp),  32'd0);
    check("rstmid_ready_aft", 32'(req_ready), 32'd1);

    run_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 0, 0);
    check("after_rst_cycle", 32'(resp_cycle), 32'd3);
    check("after_rst_rdata", got_rdata,       32'h0000_0080);
    check("after_rst_err",   32'(got_err),    32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_lane_lsu.md
# byte_lane_lsu

Load/store sequencer sitting directly upstream of the 8-bit single-byte RAM port (port A of the data RAM). It accepts one byte/half/word load or store request from the CPU core, breaks it into sequential little-endian byte accesses on the RAM port, and waits out RAM busy. For loads it assembles the bytes, zero- or sign-extends them, and returns a 32-bit result with a one-cycle response pulse.

## Interface
- ADDRESS_WIDTH, 32, width of request and RAM addresses
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block idle and accepting; transfer when req_valid & req_ready at a rising edge
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  loads only: sign-extend result
- req_addr  in  ADDRESS_WIDTH  byte address of least significant byte
- req_wdata  in  32  store data; low bytes used per size
- resp_valid  out  1  one-cycle completion pulse (loads and stores)
- resp_rdata  out  32  load result, held until next resp_valid; 0 for stores
- resp_err  out  1  qualifies resp_valid; request rejected, no RAM access
- ram_addr  out  ADDRESS_WIDTH  RAM byte address
- ram_wdata  out  8  RAM write byte
- ram_we  out  1  RAM write enable
- ram_rdata  in  8  RAM read byte
- ram_busy  in  1  RAM not ready; read data invalid

## Operation
- States: IDLE, ADDR, WAIT, DONE. req_ready = (state == IDLE) & ~reset.
- IDLE: on accept, latch write/size/signed/addr/wdata, clear byte counter and assembly register. Byte count n = 1/2/4. Size 11 -> DONE with err. Otherwise -> ADDR.
- ADDR: drive ram_addr = latched addr + k (mod 2^ADDRESS_WIDTH), ram_wdata = wdata byte k, ram_we = req_write. -> WAIT.
- WAIT: ram_we = 0, address held. If ram_busy = 0 at the edge: for loads, capture ram_rdata into byte k; for stores, take no data. Then k++ -> ADDR if k+1 < n, else -> DONE. If ram_busy = 1, stay in WAIT (no timeout).
- DONE: resp_valid = 1 for exactly one cycle, rdata/err valid. -> IDLE.
- Load extension: byte -> bits [31:8], half -> bits [31:16] filled with 0 or with the top captured bit when req_signed is set. Word is unaffected.
- Reset mid-operation: next state IDLE, ram_we = 0 on the following cycle, no resp_valid; partial stores are not undone.

## Timing
- Reset values: req_ready 0 while reset high, resp_valid 0, resp_rdata 0, resp_err 0, ram_addr 0, ram_wdata 0, ram_we 0.
- Accept at edge 0 -> ADDR in cycle 1 -> WAIT in cycle 2. Each byte costs 2 cycles plus any busy cycles.
- Latency from the accept edge to resp_valid with no busy: byte 3, half 5, word 9 cycles. Error response: 1 cycle.
- ram_we is high only in ADDR cycles of stores, one cycle per byte.
- New request accepted the cycle after DONE at the earliest. Back-to-back throughput for word ops is 1 per 10 cycles.

## Configuration
- BYTE_LANE_LSU_ALIGN_CHECK_EN defined: a half at an odd address, or a word with addr[1:0] ≠ 0, is rejected. The block goes to DONE with resp_err = 1, resp_rdata = 0, and no RAM access.
- Undefined: misaligned accesses are performed bytewise normally; resp_err is set only for size 11.

## Structure
- Package byte_lane_lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD
  - state enum
  - a bytes-per-size constant function
- One sub-module, lsu_load_extend: combinational size/sign extension of the 32-bit assembly register into resp_rdata.

## Test plan
- Store word 0x11223344 at 0x10, no busy: ram_we pulses at addrs 0x10..0x13 with data 44,33,22,11. resp_valid in cycle 9, resp_err 0.
- Signed byte load at 0x20 with RAM returning 0x80: resp_rdata 0xFFFFFF80. Unsigned load: 0x00000080. resp_valid in cycle 3.
- Half load at 0x30 with bytes 0x34, 0x12 and ram_busy high for 3 cycles in the first WAIT: resp_rdata 0x00001234, resp_valid in cycle 8.
- Word load at 0xFFFFFFFE (ADDRESS_WIDTH 32): RAM addresses FFFFFFFE, FFFFFFFF, 0, 1 in order.
- Half at 0x41: with macro, err response in cycle 1 and no ram_we/addr activity; without macro, normal 2-byte access at 0x41, 0x42. Size 11: err in both builds.
- Reset asserted during the third byte of a word store: ram_we 0 the next cycle, no resp_valid, req_ready 1 after reset falls; a following byte load completes normally.
